// File: rtl/lego_sa_sequencer.sv
// -----------------------------------------------------------------------------
// lego_sa_sequencer
//
// This module sequences one systolic-array run. A run is made of one or more
// weight tiles. Each tile goes through three phases:
//   LOAD_W : ARR_N cycles of weight shifting. w_addr counts the rows.
//            psum_clr pulses in the first cycle.
//   STREAM : offers activation beats. A beat counts only when
//            act_valid && act_ready. This phase is skipped when n_act == 0.
//   DRAIN  : 2*ARR_N-1 cycles that flush the partial sums.
// After the last tile there is a one-cycle DONE state, then the block returns
// to IDLE.
//
// Parameters
//   ARR_N        systolic array dimension (must be >= 2)
//   CNT_W        width of the length and tile counters
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        run request, sampled only in IDLE
//   abort        synchronous cancel; forces IDLE on the next edge
//   cfg_n_act    activation beats per tile (latched when start is accepted)
//   cfg_n_tiles  weight tiles per run (latched when start is accepted)
//   act_ready    the activation feeder can accept a beat
//   busy         high in LOAD_W, STREAM and DRAIN
//   done         one-cycle completion pulse (DONE state)
//   w_load_en    weight shift enable
//   w_addr       weight row index in LOAD_W, 0 otherwise
//   act_valid    activation beat offered (STREAM)
//   drain_en     partial-sum drain enable (DRAIN)
//   psum_clr     accumulator clear, first LOAD_W cycle of each tile
//   tile_idx     current tile number, 0-based; holds after DONE
//   phase        IDLE=0, LOAD_W=1, STREAM=2, DRAIN=3, DONE=4
//   perf_cycles  busy-cycle counter
//
// Build option
//   LEGO_SEQ_PERF_CNT_EN  when defined, perf_cycles is a saturating count of
//                         busy cycles. It clears when start is accepted and
//                         holds after done or abort. When undefined,
//                         perf_cycles is tied to 0.
// -----------------------------------------------------------------------------
module lego_sa_sequencer #(
  parameter int ARR_N = 16,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         cfg_n_act,
  input  logic [CNT_W-1:0]         cfg_n_tiles,
  input  logic                     act_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     w_load_en,
  output logic [$clog2(ARR_N)-1:0] w_addr,
  output logic                     act_valid,
  output logic                     drain_en,
  output logic                     psum_clr,
  output logic [CNT_W-1:0]         tile_idx,
  output logic [2:0]               phase,
  output logic [15:0]              perf_cycles
);

  localparam int AW = $clog2(ARR_N);
  // One cycle counter is shared by LOAD_W (ARR_N cycles) and DRAIN
  // (2*ARR_N-1 cycles), so it is sized for the longer of the two.
  localparam int CW = $clog2(2 * ARR_N);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(ARR_N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * ARR_N - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] n_act_q, n_act_d;
  logic [CNT_W-1:0] n_tiles_q, n_tiles_d;
  logic [CNT_W-1:0] tile_q, tile_d;

  logic start_acc;
  logic more_tiles;

  // Abort has priority over start in IDLE.
  assign start_acc = (state_q == IDLE) && start && !abort;

  // The compare uses one extra bit so that tile_q+1 cannot wrap
  // when n_tiles is at its maximum value.
  assign more_tiles = (({1'b0, tile_q} + (CNT_W + 1)'(1)) < {1'b0, n_tiles_q});

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    beat_d    = beat_q;
    n_act_d   = n_act_q;
    n_tiles_d = n_tiles_q;
    tile_d    = tile_q;

    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          n_act_d   = cfg_n_act;
          n_tiles_d = cfg_n_tiles;
          tile_d    = '0;
          cyc_d     = '0;
          beat_d    = '0;
          state_d   = (cfg_n_tiles == '0) ? DONE : LOAD_W;
        end
      end

      LOAD_W: begin
        if (cyc_q == LOAD_LAST) begin
          cyc_d   = '0;
          beat_d  = '0;
          state_d = (n_act_q == '0) ? DRAIN : STREAM;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      STREAM: begin
        if (act_ready) begin
          if (beat_q == n_act_q - CNT_W'(1)) begin
            beat_d  = '0;
            cyc_d   = '0;
            state_d = DRAIN;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end

      DRAIN: begin
        if (cyc_q == DRAIN_LAST) begin
          cyc_d = '0;
          if (more_tiles) begin
            tile_d  = tile_q + CNT_W'(1);
            state_d = LOAD_W;
          end else begin
            state_d = DONE;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition above. It also clears the
    // per-run counters, so the block comes back quiet.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cyc_d   = '0;
      beat_d  = '0;
      tile_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      beat_q    <= '0;
      n_act_q   <= '0;
      n_tiles_q <= '0;
      tile_q    <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      beat_q    <= beat_d;
      n_act_q   <= n_act_d;
      n_tiles_q <= n_tiles_d;
      tile_q    <= tile_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // The outputs are decoded only from registered state. Because of this,
  // reset drives them low at once, and at most one enable can be high.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);
    done      = (state_q == DONE);
    w_load_en = (state_q == LOAD_W);
    w_addr    = (state_q == LOAD_W) ? cyc_q[AW-1:0] : '0;
    act_valid = (state_q == STREAM);
    drain_en  = (state_q == DRAIN);
    psum_clr  = (state_q == LOAD_W) && (cyc_q == '0);
    tile_idx  = tile_q;
    phase     = state_q;
  end

`ifdef LEGO_SEQ_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_acc) begin
      perf_d = '0;
    end else if (busy && (perf_q != '1)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: doc/lego_sa_sequencer.md
LEGO_SA_SEQUENCER -- requirements
Module: lego_sa_sequencer

Interface
REQ-001 SHALL have parameter ARR_N, default 16: systolic array dimension; the weight load takes ARR_N cycles.
REQ-002 SHALL have parameter CNT_W, default 8: width of the length and tile counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: run request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1: synchronous cancel of the run in progress.
REQ-007 SHALL have port cfg_n_act, input, CNT_W: activation beats per tile.
REQ-008 SHALL have port cfg_n_tiles, input, CNT_W: weight tiles per run.
REQ-009 SHALL have port act_ready, input, 1: the activation feeder can accept a beat.
REQ-010 SHALL have port busy, output, 1: high in LOAD_W, STREAM and DRAIN.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port w_load_en, output, 1: weight shift enable.
REQ-013 SHALL have port w_addr, output, $clog2(ARR_N): weight row index.
REQ-014 SHALL have port act_valid, output, 1: activation beat offered.
REQ-015 SHALL have port drain_en, output, 1: partial-sum drain enable.
REQ-016 SHALL have port psum_clr, output, 1: accumulator clear pulse.
REQ-017 SHALL have port tile_idx, output, CNT_W: current tile number, 0-based.
REQ-018 SHALL have port phase, output, 3: state encoding IDLE=0, LOAD_W=1, STREAM=2, DRAIN=3, DONE=4.
REQ-019 SHALL have port perf_cycles, output, 16: busy-cycle count.

Function
REQ-020 SHALL latch cfg_n_act and cfg_n_tiles on the edge where start is accepted (IDLE, start=1, abort=0); later changes to the cfg inputs SHALL have no effect on the run.
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 On start acceptance with cfg_n_tiles=0, the block SHALL go to DONE.
REQ-023 On start acceptance with cfg_n_tiles>0, the block SHALL go to LOAD_W with tile_idx=0.
REQ-024 LOAD_W SHALL last exactly ARR_N cycles, with w_load_en=1 and w_addr counting 0..ARR_N-1.
REQ-025 psum_clr SHALL be high only in the first LOAD_W cycle of each tile.
REQ-026 STREAM SHALL hold act_valid=1; a beat counts only when act_valid and act_ready are both 1.
REQ-027 The block SHALL leave STREAM on the edge that completes beat cfg_n_act; if cfg_n_act=0, STREAM SHALL be skipped (LOAD_W goes directly to DRAIN).
REQ-028 DRAIN SHALL last exactly 2*ARR_N-1 cycles with drain_en=1.
REQ-029 At the end of DRAIN, the block SHALL increment tile_idx and re-enter LOAD_W if tile_idx+1 < latched n_tiles; otherwise it SHALL go to DONE.
REQ-030 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE; tile_idx SHALL hold its last value until the next start.
REQ-031 With act_ready held at 1, done SHALL be high in cycle T*(3*ARR_N-1+A)+1 after the start edge, where T = n_tiles and A = n_act.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and all enables low; if abort and start are both high in IDLE, abort SHALL win.
REQ-033 w_load_en, act_valid, drain_en and psum_clr SHALL be mutually exclusive and SHALL be 0 in IDLE and DONE.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE and set all outputs and internal counters to 0, including during a run.
REQ-035 After reset release, no run SHALL begin until start is accepted.

Configuration
REQ-036 Macro LEGO_SEQ_PERF_CNT_EN defined: perf_cycles SHALL clear on start acceptance, increment on every cycle with busy=1, saturate at 16'hFFFF, and hold after done or abort.
REQ-037 Macro LEGO_SEQ_PERF_CNT_EN undefined: perf_cycles SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-038 ARR_N=16, n_act=4, n_tiles=1, act_ready=1 -> LOAD_W 16 cycles, STREAM 4, DRAIN 31, done in cycle 52, perf_cycles=51.
REQ-039 n_tiles=3, n_act=2 -> tile_idx steps 0,1,2; three psum_clr pulses; done in cycle 148.
REQ-040 act_ready low for 5 cycles mid-STREAM -> beat count stalls, STREAM extends 5 cycles, done is 5 cycles late.
REQ-041 n_tiles=0 -> DONE the cycle after start, no enables ever high; n_act=0 -> no act_valid, DRAIN follows LOAD_W.
REQ-042 abort in DRAIN, and separately rst_n low in STREAM -> phase=0 next edge (immediately for reset), no done, outputs 0.
REQ-043 start pulsed while busy, and cfg changed mid-run -> ignored; timing matches the latched values.
